alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alarm_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an HH:MM alarm, rings on a registered time match, buzzes while ringing.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
    parameter int unsigned RING_SEC   = 30,
    parameter int unsigned BUZZ_DIV   = 25000,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_1hz,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [5:0] i_hour,
    input  logic       i_arm,
    input  logic       i_set_pos,
    input  logic       i_set_inc,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic [5:0] o_alarm_min,
    output logic [5:0] o_alarm_hour,
    output logic       o_armed,
    output logic       o_ring,
    output logic       o_buzz,
    output logic [1:0] o_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_RING   = 2'd2;
    localparam logic [1:0] ST_SNOOZE = 2'd3;

    localparam int unsigned    BW        = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [BW-1:0]  BUZZ_LAST = BW'(BUZZ_DIV - 1);
    localparam logic [15:0]    RING_LIM  = 16'(RING_SEC);

    logic [1:0]    state_q, state_d;
    logic [5:0]    alarm_min_q, alarm_min_d;
    logic [5:0]    alarm_hour_q, alarm_hour_d;
    logic          match_q, match_prev_q, match_d, match_edge;
    logic [15:0]   ring_cnt_q, ring_cnt_d, ring_inc;
    logic          ring_timeout;
    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic          buzz_q, buzz_d;
    logic          armed_q, ring_q;

`ifdef ALARM_SNOOZE_EN
    localparam logic [15:0] SNZ_LIM = 16'(SNOOZE_SEC);
    logic [15:0] snz_cnt_q, snz_cnt_d, snz_inc;
    logic        snz_timeout;

    always_comb begin
        snz_inc     = (snz_cnt_q == 16'hFFFF) ? snz_cnt_q : snz_cnt_q + 16'd1;
        snz_timeout = i_tick_1hz && (snz_inc == SNZ_LIM);
        snz_cnt_d   = '0;
        if (state_d == ST_SNOOZE && state_q == ST_SNOOZE)
            snz_cnt_d = i_tick_1hz ? snz_inc : snz_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) snz_cnt_q <= '0;
        else     snz_cnt_q <= snz_cnt_d;
    end
`else
    logic unused_snooze;
    assign unused_snooze = i_snooze | (SNOOZE_SEC == 0);
`endif

    // Compare uses the alarm value before any same-cycle increment.
    always_comb begin
        match_d      = (i_hour == alarm_hour_q) && (i_min == alarm_min_q) && (i_sec == 6'd0);
        match_edge   = match_q && !match_prev_q;
        ring_inc     = (ring_cnt_q == 16'hFFFF) ? ring_cnt_q : ring_cnt_q + 16'd1;
        ring_timeout = i_tick_1hz && (ring_inc == RING_LIM);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (i_arm)           state_d = ST_IDLE;
                else if (match_edge) state_d = ST_RING;
            end
            ST_RING: begin
                if (i_arm)                       state_d = ST_IDLE;
                else if (i_stop || ring_timeout) state_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
                else if (i_snooze)               state_d = ST_SNOOZE;
`endif
            end
            ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (i_arm)            state_d = ST_IDLE;
                else if (snz_timeout) state_d = ST_RING;
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_comb begin
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        if (i_set_inc && state_q != ST_RING) begin
            if (i_set_pos) alarm_hour_d = (alarm_hour_q == 6'd23) ? 6'd0 : alarm_hour_q + 6'd1;
            else           alarm_min_d  = (alarm_min_q  == 6'd59) ? 6'd0 : alarm_min_q  + 6'd1;
        end
    end

    // Counters only advance while staying in RING; entry and exit both clear them.
    always_comb begin
        ring_cnt_d = '0;
        buzz_cnt_d = '0;
        buzz_d     = 1'b0;
        if (state_d == ST_RING && state_q == ST_RING) begin
            ring_cnt_d = i_tick_1hz ? ring_inc : ring_cnt_q;
            if (buzz_cnt_q == BUZZ_LAST) begin
                buzz_cnt_d = '0;
                buzz_d     = ~buzz_q;
            end else begin
                buzz_cnt_d = buzz_cnt_q + BW'(1);
                buzz_d     = buzz_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alarm_min_q  <= '0;
            alarm_hour_q <= '0;
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
            ring_cnt_q   <= '0;
            buzz_cnt_q   <= '0;
            buzz_q       <= 1'b0;
            armed_q      <= 1'b0;
            ring_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            match_q      <= match_d;
            match_prev_q <= match_q;
            ring_cnt_q   <= ring_cnt_d;
            buzz_cnt_q   <= buzz_cnt_d;
            buzz_q       <= buzz_d;
            armed_q      <= (state_d != ST_IDLE);
            ring_q       <= (state_d == ST_RING);
        end
    end

    assign o_alarm_min  = alarm_min_q;
    assign o_alarm_hour = alarm_hour_q;
    assign o_armed      = armed_q;
    assign o_ring       = ring_q;
    assign o_buzz       = buzz_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: vector table for single-cycle behaviour plus hand sequences for multi-cycle cases.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_tick_1hz = 1'b0;
    logic [5:0] i_sec = 6'd10, i_min = 6'd30, i_hour = 6'd5;
    logic       i_arm = 1'b0, i_set_pos = 1'b0, i_set_inc = 1'b0, i_stop = 1'b0, i_snooze = 1'b0;
    logic [5:0] o_alarm_min, o_alarm_hour;
    logic       o_armed, o_ring, o_buzz;
    logic [1:0] o_state;

    int tests = 0;
    int failed = 0;

    alarm_ctrl #(.RING_SEC(3), .BUZZ_DIV(4), .SNOOZE_SEC(2)) dut (
        .clk(clk), .rst(rst), .i_tick_1hz(i_tick_1hz),
        .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .i_arm(i_arm), .i_set_pos(i_set_pos), .i_set_inc(i_set_inc),
        .i_stop(i_stop), .i_snooze(i_snooze),
        .o_alarm_min(o_alarm_min), .o_alarm_hour(o_alarm_hour),
        .o_armed(o_armed), .o_ring(o_ring), .o_buzz(o_buzz), .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, arm, stop, snooze, set_inc, set_pos;
        logic [5:0] hour, min, sec;
        logic [5:0] e_hour, e_min;
        logic       e_armed, e_ring;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, a, st, sn, inc, pos,
                                input logic [5:0] h, m, s, eh, em,
                                input logic ea, er, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.arm = a; v.stop = st; v.snooze = sn; v.set_inc = inc; v.set_pos = pos;
        v.hour = h; v.min = m; v.sec = s;
        v.e_hour = eh; v.e_min = em; v.e_armed = ea; v.e_ring = er; v.e_state = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_time(input logic [5:0] h, m, s);
        i_hour = h; i_min = m; i_sec = s;
    endtask

    task automatic tick();
        i_tick_1hz = 1'b1; step(); i_tick_1hz = 1'b0;
    endtask

    initial begin
        // rst arm stop snz inc pos | hh mm ss | e_hh e_mm armed ring state
        vecs.push_back(mk(1,0,0,0,0,0, 5,30,10, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 5,30,10, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1, 5,30,10, 1,1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 5,30,10, 1,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,0, 5,30,10, 1,2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 5,30,10, 1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 5,30,10, 1,2,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0, 5,30,10, 1,2,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 5,30,10, 1,2,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0, 5,30,10, 1,2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 5,30,10, 1,2,0,0,0));
        // match while idle is ignored; arming during a held match does not fire
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,0,   1,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,1,   1,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,1,1,2));
        vecs.push_back(mk(0,0,1,0,0,0, 1,2,0,   1,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,0,   1,2,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,1,   1,2,1,0,1));
        // increment coinciding with match evaluation compares the old value
        vecs.push_back(mk(0,0,0,0,1,0, 1,2,0,   1,3,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,   1,3,1,1,2));
        vecs.push_back(mk(0,0,0,0,1,0, 1,2,0,   1,3,1,1,2));
        vecs.push_back(mk(0,1,1,0,0,0, 1,2,0,   1,3,0,0,0));

        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; i_arm = vecs[i].arm; i_stop = vecs[i].stop;
            i_snooze = vecs[i].snooze; i_set_inc = vecs[i].set_inc; i_set_pos = vecs[i].set_pos;
            set_time(vecs[i].hour, vecs[i].min, vecs[i].sec);
            step();
            check($sformatf("row%0d.min", i),   8'(o_alarm_min),  8'(vecs[i].e_min));
            check($sformatf("row%0d.hour", i),  8'(o_alarm_hour), 8'(vecs[i].e_hour));
            check($sformatf("row%0d.armed", i), 8'(o_armed),      8'(vecs[i].e_armed));
            check($sformatf("row%0d.ring", i),  8'(o_ring),       8'(vecs[i].e_ring));
            check($sformatf("row%0d.buzz", i),  8'(o_buzz),       8'd0);
            check($sformatf("row%0d.state", i), 8'(o_state),      8'(vecs[i].e_state));
        end
        rst = 0; i_arm = 0; i_stop = 0; i_snooze = 0; i_set_inc = 0; i_set_pos = 0;

        // Setting with wraps, starting from reset
        set_time(5, 30, 10);
        rst = 1; step(); rst = 0;
        check("rst.min", 8'(o_alarm_min), 8'd0);
        i_set_inc = 1; i_set_pos = 0; steps(7);
        i_set_pos = 1; steps(25);
        i_set_inc = 0; step();
        check("set.min7", 8'(o_alarm_min), 8'd7);
        check("set.hour1", 8'(o_alarm_hour), 8'd1);
        i_set_inc = 1; i_set_pos = 1; steps(23);
        i_set_inc = 0; step();
        check("set.hourwrap", 8'(o_alarm_hour), 8'd0);
        i_set_inc = 1; i_set_pos = 0; steps(53);
        i_set_inc = 0; step();
        check("set.minwrap", 8'(o_alarm_min), 8'd0);
        check("set.nocarry", 8'(o_alarm_hour), 8'd0);
        i_set_inc = 1; i_set_pos = 0; steps(7);
        i_set_pos = 1; steps(1);
        i_set_inc = 0; step();
        check("set.0107.min", 8'(o_alarm_min), 8'd7);
        check("set.0107.hour", 8'(o_alarm_hour), 8'd1);

        // Firing latency and buzz waveform
        i_arm = 1; step(); i_arm = 0;
        check("fire.armed", 8'(o_state), 8'd1);
        set_time(1, 6, 59); step();
        set_time(1, 7, 0); step();
        check("fire.lat1.ring", 8'(o_ring), 8'd0);
        step();
        check("fire.lat2.ring", 8'(o_ring), 8'd1);
        check("fire.state", 8'(o_state), 8'd2);
        check("fire.buzz0", 8'(o_buzz), 8'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("buzz.k%0d", k), 8'(o_buzz), 8'(((k / 4) % 2)));
        end

        // Ring timeout after RING_SEC ticks
        tick(); step();
        check("tmo.tick1", 8'(o_state), 8'd2);
        tick(); step();
        check("tmo.tick2", 8'(o_state), 8'd2);
        tick();
        check("tmo.state", 8'(o_state), 8'd1);
        check("tmo.buzz", 8'(o_buzz), 8'd0);
        check("tmo.ring", 8'(o_ring), 8'd0);
        check("tmo.armed", 8'(o_armed), 8'd1);
        steps(4);
        check("tmo.noretrig", 8'(o_state), 8'd1);

        // Snooze request during ring
        set_time(1, 7, 1); step();
        set_time(1, 7, 0); steps(2);
        check("snz.ringing", 8'(o_state), 8'd2);
        i_snooze = 1; step(); i_snooze = 0;
`ifdef ALARM_SNOOZE_EN
        check("snz.state", 8'(o_state), 8'd3);
        check("snz.ring", 8'(o_ring), 8'd0);
        check("snz.buzz", 8'(o_buzz), 8'd0);
        check("snz.armed", 8'(o_armed), 8'd1);
        tick(); step();
        check("snz.tick1", 8'(o_state), 8'd3);
        tick();
        check("snz.back", 8'(o_state), 8'd2);
        check("snz.back.ring", 8'(o_ring), 8'd1);
        tick(); step(); tick(); step();
        check("snz.ringclr", 8'(o_state), 8'd2);
        tick();
        check("snz.tmo", 8'(o_state), 8'd1);
`else
        check("snz.ignored", 8'(o_state), 8'd2);
        tick(); step(); tick();
        check("snz.stillring", 8'(o_state), 8'd2);
        tick();
        check("snz.tmo", 8'(o_state), 8'd1);
`endif

        // Reset mid-ring while the buzzer is high
        set_time(1, 7, 1); step();
        set_time(1, 7, 0); steps(2);
        check("rr.ring", 8'(o_ring), 8'd1);
        steps(5);
        check("rr.buzzhi", 8'(o_buzz), 8'd1);
        rst = 1; step(); rst = 0;
        check("rr.buzz", 8'(o_buzz), 8'd0);
        check("rr.ring0", 8'(o_ring), 8'd0);
        check("rr.armed", 8'(o_armed), 8'd0);
        check("rr.state", 8'(o_state), 8'd0);
        check("rr.min", 8'(o_alarm_min), 8'd0);
        check("rr.hour", 8'(o_alarm_hour), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
